// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: horizontal and vertical four-phase FSMs producing
// registered syncs, visibility flags, frame/line pulses and a linear pixel address.
module vga_timing_gen #(
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned H_FP     = 16,
   parameter int unsigned H_SYNC   = 96,
   parameter int unsigned H_BP     = 48,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned V_FP     = 10,
   parameter int unsigned V_SYNC   = 2,
   parameter int unsigned V_BP     = 33
) (
   input  logic        VGA_clock,
   input  logic        reset,
   input  logic        en,
   output logic        VGA_HS,
   output logic        VGA_VS,
   output logic        h_sync,
   output logic        v_sync,
   output logic        active_area,
   output logic [19:0] vAddress,
   output logic        frame_start,
   output logic        line_end
);

   typedef enum logic [1:0] {H_ACT, H_FRONT, H_SYNCP, H_BACK} h_state_t;
   typedef enum logic [1:0] {V_ACT, V_FRONT, V_SYNCP, V_BACK} v_state_t;

   h_state_t    h_state;
   h_state_t    h_state_next;
   v_state_t    v_state;
   v_state_t    v_state_next;
   logic [9:0]  h_cnt;
   logic [9:0]  v_cnt;
   logic [9:0]  h_len;
   logic [9:0]  v_len;
   logic [19:0] addr_next;
   logic [19:0] addr_cur;
   logic        h_last;
   logic        line_last;
   logic        v_last;
   logic        pix_active;
   logic        pix_first;

   // Last in-state count and successor for each phase.
   always_comb begin
      h_len        = 10'(H_ACTIVE - 1);
      h_state_next = H_FRONT;
      unique case (h_state)
         H_ACT: begin
            h_len        = 10'(H_ACTIVE - 1);
            h_state_next = H_FRONT;
         end
         H_FRONT: begin
            h_len        = 10'(H_FP - 1);
            h_state_next = H_SYNCP;
         end
         H_SYNCP: begin
            h_len        = 10'(H_SYNC - 1);
            h_state_next = H_BACK;
         end
         H_BACK: begin
            h_len        = 10'(H_BP - 1);
            h_state_next = H_ACT;
         end
      endcase
   end

   always_comb begin
      v_len        = 10'(V_ACTIVE - 1);
      v_state_next = V_FRONT;
      unique case (v_state)
         V_ACT: begin
            v_len        = 10'(V_ACTIVE - 1);
            v_state_next = V_FRONT;
         end
         V_FRONT: begin
            v_len        = 10'(V_FP - 1);
            v_state_next = V_SYNCP;
         end
         V_SYNCP: begin
            v_len        = 10'(V_SYNC - 1);
            v_state_next = V_BACK;
         end
         V_BACK: begin
            v_len        = 10'(V_BP - 1);
            v_state_next = V_ACT;
         end
      endcase
   end

   // The vertical FSM keys off the unregistered end-of-line so both FSMs wrap together.
   always_comb begin
      h_last     = (h_cnt == h_len);
      line_last  = h_last && (h_state == H_BACK);
      v_last     = (v_cnt == v_len);
      pix_active = (h_state == H_ACT) && (v_state == V_ACT);
      pix_first  = pix_active && (h_cnt == 10'd0) && (v_cnt == 10'd0);
      addr_cur   = pix_first ? 20'd0 : addr_next;
   end

   always_ff @(posedge VGA_clock or negedge reset) begin
      if (!reset) begin
         h_state     <= H_ACT;
         v_state     <= V_ACT;
         h_cnt       <= 10'd0;
         v_cnt       <= 10'd0;
         addr_next   <= 20'd0;
         vAddress    <= 20'd0;
         VGA_HS      <= 1'b1;
         VGA_VS      <= 1'b1;
         h_sync      <= 1'b0;
         v_sync      <= 1'b0;
         active_area <= 1'b0;
         frame_start <= 1'b0;
         line_end    <= 1'b0;
      end else if (en) begin
         if (h_last) begin
            h_cnt   <= 10'd0;
            h_state <= h_state_next;
         end else begin
            h_cnt <= h_cnt + 10'd1;
         end

         if (line_last) begin
            if (v_last) begin
               v_cnt   <= 10'd0;
               v_state <= v_state_next;
            end else begin
               v_cnt <= v_cnt + 10'd1;
            end
         end

         // Outputs describe the pixel the FSMs held before this edge.
         VGA_HS      <= (h_state != H_SYNCP);
         VGA_VS      <= (v_state != V_SYNCP);
         h_sync      <= (h_state == H_ACT);
         v_sync      <= (v_state == V_ACT);
         active_area <= pix_active;
         frame_start <= pix_first;
         line_end    <= line_last;

         if (pix_active) begin
            vAddress  <= addr_cur;
            addr_next <= addr_cur + 20'd1;
         end
      end
   end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: random enable stalls and a mid-frame reset,
// checked against a raster model computed from pixel coordinates.
module tb_vga_timing_gen;

   localparam int unsigned HA = 16;
   localparam int unsigned HF = 3;
   localparam int unsigned HS = 4;
   localparam int unsigned HB = 5;
   localparam int unsigned VA = 6;
   localparam int unsigned VF = 2;
   localparam int unsigned VS = 2;
   localparam int unsigned VB = 3;
   localparam int unsigned LINE  = HA + HF + HS + HB;
   localparam int unsigned LINES = VA + VF + VS + VB;
   localparam int unsigned FRAME = LINE * LINES;

   typedef struct packed {
      logic        hs;
      logic        vs;
      logic        hsy;
      logic        vsy;
      logic        act;
      logic        fs;
      logic        le;
      logic [19:0] addr;
   } out_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        en = 1'b0;
   logic        vga_hs, vga_vs, h_sync, v_sync, active_area, frame_start, line_end;
   logic [19:0] v_address;

   out_t q[$];
   out_t held;
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;

   vga_timing_gen #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
   ) dut (
      .VGA_clock  (clk),
      .reset      (rst_n),
      .en         (en),
      .VGA_HS     (vga_hs),
      .VGA_VS     (vga_vs),
      .h_sync     (h_sync),
      .v_sync     (v_sync),
      .active_area(active_area),
      .vAddress   (v_address),
      .frame_start(frame_start),
      .line_end   (line_end)
   );

   function automatic out_t rst_vals();
      out_t o;
      o.hs = 1'b1; o.vs = 1'b1; o.hsy = 1'b0; o.vsy = 1'b0;
      o.act = 1'b0; o.fs = 1'b0; o.le = 1'b0; o.addr = 20'd0;
      return o;
   endfunction

   // Expected outputs for the idx-th pixel since reset, from raster coordinates.
   function automatic out_t model(int unsigned idx);
      out_t        o;
      int unsigned p = idx % FRAME;
      int unsigned x = p % LINE;
      int unsigned y = p / LINE;
      o.hsy  = (x < HA);
      o.vsy  = (y < VA);
      o.hs   = !((x >= HA + HF) && (x < HA + HF + HS));
      o.vs   = !((y >= VA + VF) && (y < VA + VF + VS));
      o.act  = o.hsy && o.vsy;
      o.fs   = (x == 0) && (y == 0);
      o.le   = (x == LINE - 1);
      if (o.act)       o.addr = 20'(y * HA + x);
      else if (y < VA) o.addr = 20'(y * HA + HA - 1);
      else             o.addr = 20'(HA * VA - 1);
      return o;
   endfunction

   function automatic out_t observed();
      out_t o;
      o.hs = vga_hs; o.vs = vga_vs; o.hsy = h_sync; o.vsy = v_sync;
      o.act = active_area; o.fs = frame_start; o.le = line_end; o.addr = v_address;
      return o;
   endfunction

   function automatic string fmt(out_t o);
      return $sformatf("HS=%b VS=%b h=%b v=%b act=%b fs=%b le=%b addr=%0d",
                       o.hs, o.vs, o.hsy, o.vsy, o.act, o.fs, o.le, o.addr);
   endfunction

   task automatic check(string name, out_t got, out_t exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s @%0t: got {%s} expected {%s}", name, $time, fmt(got), fmt(exp));
      end
   endtask

   // Monitor: each enabled edge consumes one scoreboard entry; stalled edges must hold.
   initial begin
      logic e_s;
      logic r_s;
      out_t exp;
      forever begin
         @(posedge clk);
         e_s = en;
         r_s = rst_n;
         #1;
         if (r_s && e_s) begin
            if (q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL scoreboard_empty @%0t: got no entry expected one", $time);
            end else begin
               exp = q.pop_front();
               check("pixel", observed(), exp);
               held = exp;
            end
         end else if (r_s) begin
            check("stall_hold", observed(), held);
         end
      end
   end

   initial begin
      int unsigned idx;
      int unsigned target;
      idx  = 0;
      held = rst_vals();
      #1 rst_n = 1'b0;
      en = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_values", observed(), rst_vals());
      rst_n = 1'b1;

      // Two full frames plus part of a third, stopping at line 3 pixel 10.
      target = 2 * FRAME + 3 * LINE + 10;
      for (int c = 0; c < 20000 && idx < target; c++) begin
         en = ($urandom_range(3) != 0);
         if (en) begin
            q.push_back(model(idx));
            idx++;
         end
         @(negedge clk);
      end

      #2 rst_n = 1'b0;
      #1;
      check("async_reset", observed(), rst_vals());
      held = rst_vals();
      en = 1'b1;
      repeat (2) @(negedge clk);
      check("reset_hold", observed(), rst_vals());
      rst_n = 1'b1;

      idx = 0;
      target = FRAME + 2 * LINE;
      for (int c = 0; c < 20000 && idx < target; c++) begin
         en = ($urandom_range(3) != 0);
         if (en) begin
            q.push_back(model(idx));
            idx++;
         end
         @(negedge clk);
      end
      en = 1'b0;
      repeat (2) @(negedge clk);

      total++;
      if (q.size() != 0 || idx != target) begin
         bad++;
         $display("FAIL drain: got %0d pending, %0d pixels expected 0 pending, %0d pixels",
                  q.size(), idx, target);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameter H_FP, default 16, horizontal front porch in clocks.
REQ-003 SHALL have parameter H_SYNC, default 96, horizontal sync pulse in clocks.
REQ-004 SHALL have parameter H_BP, default 48, horizontal back porch in clocks.
REQ-005 SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-006 SHALL have parameter V_FP, default 10, vertical front porch in lines.
REQ-007 SHALL have parameter V_SYNC, default 2, vertical sync pulse in lines.
REQ-008 SHALL have parameter V_BP, default 33, vertical back porch in lines.
REQ-009 SHALL have port VGA_clock, input, 1, pixel clock; the block uses this single clock and no other.
REQ-010 SHALL have port reset, input, 1, asynchronous, active-low reset.
REQ-011 SHALL have port en, input, 1, pixel advance enable; while en=0 all state and outputs hold.
REQ-012 SHALL have port VGA_HS, output, 1, physical horizontal sync, active-low.
REQ-013 SHALL have port VGA_VS, output, 1, physical vertical sync, active-low.
REQ-014 SHALL have port h_sync, output, 1, high during the visible part of a line.
REQ-015 SHALL have port v_sync, output, 1, high during the visible lines of a frame.
REQ-016 SHALL have port active_area, output, 1, h_sync AND v_sync.
REQ-017 SHALL have port vAddress, output, 20, linear pixel address.
REQ-018 SHALL have port frame_start, output, 1, one-clock pulse on the first visible pixel of a frame.
REQ-019 SHALL have port line_end, output, 1, one-clock pulse on the last clock of every line, including blanking lines.

Function
REQ-020 Horizontal FSM SHALL use the states H_ACT, H_FRONT, H_SYNCP and H_BACK, lasting H_ACTIVE, H_FP, H_SYNC and H_BP enabled clocks respectively, in that cyclic order.
REQ-021 Vertical FSM SHALL use the states V_ACT, V_FRONT, V_SYNCP and V_BACK, lasting V_ACTIVE, V_FP, V_SYNC and V_BP lines; it advances only on an enabled clock where line_end=1.
REQ-022 Line period SHALL equal the sum of the H parameters (800 at defaults); frame period SHALL equal the sum of the V parameters in lines (525 at defaults).
REQ-023 In-state counters SHALL be 10-bit horizontal and 10-bit vertical; each clears to 0 on every state transition.
REQ-024 All outputs SHALL be registered, lagging the FSM state by exactly one enabled clock.
REQ-025 VGA_HS SHALL be 0 iff the horizontal state is H_SYNCP; VGA_VS SHALL be 0 iff the vertical state is V_SYNCP.
REQ-026 vAddress SHALL be 0 on the first visible pixel and SHALL increment by 1 on each active_area pixel, giving row*H_ACTIVE+col with no multiplier.
REQ-027 vAddress SHALL hold its value outside the active area.
REQ-028 vAddress SHALL reach H_ACTIVE*V_ACTIVE-1 (307199 at defaults) on the last visible pixel, then return to 0 on the first visible pixel of the next frame.
REQ-029 When en=0, no counter, state or output SHALL change; frame_start and line_end SHALL hold their current values and must be qualified by en.
REQ-030 When the last pixel of the last V_BACK line coincides with line_end, both FSMs SHALL wrap to H_ACT/V_ACT on the same clock.

Reset
REQ-031 While reset=0, both FSMs SHALL be forced to state ACT with counters 0 and vAddress 0.
REQ-032 While reset=0, outputs SHALL be VGA_HS=1, VGA_VS=1, h_sync=0, v_sync=0, active_area=0, frame_start=0, line_end=0.
REQ-033 On the first enabled clock after reset deasserts, outputs SHALL present pixel (0,0): active_area=1, frame_start=1, vAddress=0.
REQ-034 Reset asserted mid-frame SHALL take effect immediately and asynchronously, with no partial line completed.

Verification
REQ-035 Release reset with en=1 -> next edge gives frame_start=1, active_area=1, vAddress=0; h_sync stays high for 640 clocks.
REQ-036 Line timing -> VGA_HS goes low 656 clocks after line start for 96 clocks; line_end pulses every 800 clocks.
REQ-037 Frame timing -> v_sync is high for 480 lines; VGA_VS goes low at line 490 for 2 lines; frame_start recurs every 420000 clocks.
REQ-038 Addressing -> vAddress equals 639 at the end of line 0, 640 at the start of line 1, and 307199 at the last pixel, then 0 at the next frame_start.
REQ-039 Toggle en pseudo-randomly -> every output sequence is identical to the en=1 sequence with stalled cycles removed.
REQ-040 Assert reset at line 200, pixel 300 -> outputs immediately take their reset values; after release the frame restarts at vAddress 0.
